// File: rtl/axi4_duth_noc_pkg.sv
// Shared NoC types: flit-type encoding in the two LSBs of every flit,
// plus the input-buffer framing-checker state.
package axi4_duth_noc_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic {
        IDLE,
        IN_PKT
    } inp_buf_state_t;

    function automatic logic flit_is_head(input logic [1:0] ftype);
        return ftype == FLIT_HEAD;
    endfunction

    function automatic logic flit_is_body(input logic [1:0] ftype);
        return ftype == FLIT_BODY;
    endfunction

    function automatic logic flit_is_tail(input logic [1:0] ftype);
        return ftype == FLIT_TAIL;
    endfunction

    function automatic logic flit_is_single(input logic [1:0] ftype);
        return ftype == FLIT_SINGLE;
    endfunction

endpackage

// File: rtl/rtr_inp_buffer.sv
// Router input-port FIFO with credit return, sticky overflow flag and an
// optional write-side packet-framing checker.
module rtr_inp_buffer
    import axi4_duth_noc_pkg::*;
#(
    parameter int FLIT_WIDTH = 16,
    parameter int BUF_DEPTH  = 4,
    parameter bit CHK_PROTO  = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [FLIT_WIDTH-1:0]          data_in,
    input  logic                           valid_in,
    output logic                           credit_out,
    output logic [FLIT_WIDTH-1:0]          data_out,
    output logic                           valid_out,
    input  logic                           pop,
    output logic [$clog2(BUF_DEPTH+1)-1:0] count,
    output logic                           ovf_err,
    output logic                           proto_err
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH+1);

    logic [FLIT_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  rd_en;
    logic                  wr_en;

    assign valid_out = (count != '0);
    assign rd_en     = pop && valid_out;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_en     = valid_in && ((count < CW'(BUF_DEPTH)) || rd_en);
    assign data_out  = mem[rd_ptr];

    // NOTE: storage has no reset; valid_out masks stale contents, and leaving it
    // out of the reset tree lets the array map onto plain flops or LUT RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            credit_out <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_en)
                count <= count + 1'b1;
            else if (!wr_en && rd_en)
                count <= count - 1'b1;
            credit_out <= rd_en;
            if (valid_in && !wr_en)
                ovf_err <= 1'b1;
        end
    end

    if (CHK_PROTO) begin : g_proto
        inp_buf_state_t state_q;
        inp_buf_state_t state_d;
        logic           err_d;
        logic [1:0]     ftype;

        assign ftype = data_in[1:0];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= IDLE;
                proto_err <= 1'b0;
            end else begin
                state_q <= state_d;
                if (err_d)
                    proto_err <= 1'b1;
            end
        end

        // NOTE: every output of this block is defaulted first so no path
        // leaves a variable unassigned, which would infer a latch.
        always_comb begin
            state_d = state_q;
            err_d   = 1'b0;
            if (wr_en) begin
                unique case (state_q)
                    IDLE: begin
                        if (flit_is_head(ftype))
                            state_d = IN_PKT;
                        else if (flit_is_body(ftype) || flit_is_tail(ftype))
                            err_d = 1'b1;
                    end
                    IN_PKT: begin
                        if (flit_is_tail(ftype)) begin
                            state_d = IDLE;
                        end else if (flit_is_head(ftype)) begin
                            err_d = 1'b1;
                        end else if (flit_is_single(ftype)) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end else begin : g_no_proto
        assign proto_err = 1'b0;
    end

`ifndef SYNTHESIS
    a_no_x_type: assert property (@(posedge clk) disable iff (rst)
        valid_in |-> !$isunknown(data_in[1:0]));
    a_count_max: assert property (@(posedge clk) disable iff (rst)
        count <= CW'(BUF_DEPTH));
    a_valid_out: assert property (@(posedge clk) disable iff (rst)
        valid_out == (count != '0));
`endif

endmodule

// File: tb/tb_rtr_inp_buffer.sv
// Directed bench for rtr_inp_buffer: queue-based reference model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_rtr_inp_buffer;
    import axi4_duth_noc_pkg::*;

    localparam int FW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [FW-1:0] data_in = '0;
    logic          valid_in = 1'b0;
    logic          pop = 1'b0;
    logic          credit_out;
    logic [FW-1:0] data_out;
    logic          valid_out;
    logic [CW-1:0] count;
    logic          ovf_err;
    logic          proto_err;

    rtr_inp_buffer #(
        .FLIT_WIDTH(FW),
        .BUF_DEPTH (DEPTH),
        .CHK_PROTO (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .credit_out(credit_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .pop       (pop),
        .count     (count),
        .ovf_err   (ovf_err),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: contents as a queue, flags as plain bits.
    logic [FW-1:0] mq[$];
    bit m_credit = 0;
    bit m_ovf    = 0;
    bit m_proto  = 0;
    bit m_open   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] flit(input logic [1:0] t, input logic [13:0] seq);
        return {seq, t};
    endfunction

    task automatic model_update(input logic vin, input logic [FW-1:0] din, input logic p);
        bit rd, wr;
        logic [1:0] t;
        rd = p && (mq.size() != 0);
        wr = vin && ((mq.size() < DEPTH) || rd);
        m_credit = rd;
        if (vin && !wr)
            m_ovf = 1;
        if (wr) begin
            t = din[1:0];
            if (!m_open && (t == FLIT_BODY || t == FLIT_TAIL))
                m_proto = 1;
            if (m_open && (t == FLIT_HEAD || t == FLIT_SINGLE))
                m_proto = 1;
            if (t == FLIT_HEAD)
                m_open = 1;
            else if (t == FLIT_TAIL || t == FLIT_SINGLE)
                m_open = 0;
        end
        if (rd)
            void'(mq.pop_front());
        if (wr)
            mq.push_back(din);
    endtask

    task automatic model_clear();
        mq.delete();
        m_credit = 0;
        m_ovf    = 0;
        m_proto  = 0;
        m_open   = 0;
    endtask

    // One clock cycle with the given inputs; returns 2 time units after the edge.
    task automatic cycle(input logic vin, input logic [FW-1:0] din, input logic p);
        valid_in = vin;
        data_in  = din;
        pop      = p;
        @(posedge clk);
        model_update(vin, din, p);
        #2;
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        pop      = 1'b0;
        rst      = 1'b1;
        model_clear();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        check("valid_out", valid_out, mq.size() != 0);
        check("count", count, mq.size());
        if (mq.size() != 0)
            check("data_out", data_out, mq[0]);
        check("credit_out", credit_out, m_credit);
        check("ovf_err", ovf_err, m_ovf);
        check("proto_err", proto_err, m_proto);
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        check("rst_count", count, 0);
        check("rst_valid", valid_out, 0);
        check("rst_credit", credit_out, 0);
        check("rst_ovf", ovf_err, 0);
        check("rst_proto", proto_err, 0);

        // Fill then drain.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, flit(FLIT_SINGLE, 14'(i + 1)), 1'b0);
            check("fill_valid", valid_out, 1);
        end
        check("fill_count", count, 4);
        for (int i = 0; i < 4; i++) begin
            check("drain_data", data_out, (i + 1) * 4 + 3);
            cycle(1'b0, '0, 1'b1);
            check("drain_credit", credit_out, 1);
        end
        cycle(1'b0, '0, 1'b0);
        check("drain_credit_end", credit_out, 0);
        check("drain_count", count, 0);

        // Full: simultaneous write+pop, then overflow.
        for (int i = 5; i <= 8; i++)
            cycle(1'b1, flit(FLIT_SINGLE, 14'(i)), 1'b0);
        cycle(1'b1, flit(FLIT_SINGLE, 14'd9), 1'b1);
        check("full_sim_count", count, 4);
        check("full_sim_credit", credit_out, 1);
        check("full_sim_ovf", ovf_err, 0);
        cycle(1'b1, flit(FLIT_SINGLE, 14'd10), 1'b0);
        check("ovf_set", ovf_err, 1);
        check("ovf_count", count, 4);
        cycle(1'b0, '0, 1'b0);
        check("ovf_sticky", ovf_err, 1);
        check("ovf_head", data_out, 16'h001b);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Pop on empty.
        cycle(1'b0, '0, 1'b1);
        check("empty_pop_credit", credit_out, 0);
        check("empty_pop_count", count, 0);
        cycle(1'b0, '0, 1'b0);
        check("empty_pop_credit2", credit_out, 0);
        check("ovf_still", ovf_err, 1);

        do_reset();
        check("reset_ovf", ovf_err, 0);

        // Wrap-around: 11 flits with pop every cycle after the first.
        cycle(1'b1, flit(FLIT_SINGLE, 14'd20), 1'b0);
        for (int i = 1; i <= 10; i++) begin
            check("wrap_data", data_out, (19 + i) * 4 + 3);
            cycle(1'b1, flit(FLIT_SINGLE, 14'(20 + i)), 1'b1);
            check("wrap_count_le1", count <= 1, 1);
        end
        check("wrap_last", data_out, 30 * 4 + 3);
        cycle(1'b0, '0, 1'b1);
        check("wrap_empty", count, 0);

        // Framing: head, body, head (violation), tail; then single, tail.
        cycle(1'b1, flit(FLIT_HEAD, 14'd40), 1'b0);
        cycle(1'b1, flit(FLIT_BODY, 14'd41), 1'b0);
        check("frame_ok", proto_err, 0);
        cycle(1'b1, flit(FLIT_HEAD, 14'd42), 1'b0);
        check("frame_err", proto_err, 1);
        cycle(1'b1, flit(FLIT_TAIL, 14'd43), 1'b0);
        cycle(1'b1, flit(FLIT_SINGLE, 14'd44), 1'b1);
        cycle(1'b1, flit(FLIT_TAIL, 14'd45), 1'b1);
        check("frame_sticky", proto_err, 1);
        check("frame_count", count, 4);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Reset with three flits buffered.
        do_reset();
        for (int i = 0; i < 3; i++)
            cycle(1'b1, flit(FLIT_SINGLE, 14'(50 + i)), 1'b0);
        check("pre_rst_count", count, 3);
        rst = 1'b1;
        model_clear();
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", valid_out, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1);
            check("post_rst_credit", credit_out, 0);
            check("post_rst_valid", valid_out, 0);
        end

        cycle(1'b0, '0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rtr_inp_buffer.md
RTR_INP_BUFFER -- requirements
Module: rtr_inp_buffer

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 16: flit width in bits.
REQ-002 SHALL have parameter BUF_DEPTH, default 4: FIFO slots, power of 2, >= 2.
REQ-003 SHALL have parameter CHK_PROTO, default 1'b1: enables the packet-framing checker.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port data_in  input  FLIT_WIDTH  flit from the upstream link.
REQ-007 SHALL have port valid_in  input  1  upstream flit valid; one flit per cycle.
REQ-008 SHALL have port credit_out  output  1  one-cycle pulse returning one slot credit upstream.
REQ-009 SHALL have port data_out  output  FLIT_WIDTH  head-of-FIFO flit to the router per-input logic.
REQ-010 SHALL have port valid_out  output  1  FIFO non-empty.
REQ-011 SHALL have port pop  input  1  dequeue request from the router (its back_pop/SA grant).
REQ-012 SHALL have port count  output  $clog2(BUF_DEPTH+1)  current occupancy.
REQ-013 SHALL have port ovf_err  output  1  sticky overflow flag.
REQ-014 SHALL have port proto_err  output  1  sticky framing-violation flag.

Function
REQ-015 SHALL implement a circular FIFO with wr_ptr and rd_ptr of $clog2(BUF_DEPTH) bits, wrapping modulo BUF_DEPTH, plus an occupancy counter.
REQ-016 SHALL accept a write when valid_in=1 and (count<BUF_DEPTH or pop=1 with valid_out=1).
REQ-017 SHALL have no bypass: a flit written in cycle N is first visible on data_out/valid_out in cycle N+1.
REQ-018 SHALL drive data_out combinationally from the rd_ptr slot; the value is don't-care when valid_out=0.
REQ-019 SHALL dequeue on pop=1 with valid_out=1; pop with valid_out=0 SHALL be ignored, with no pointer or count change.
REQ-020 SHALL handle a simultaneous accepted write and valid pop by advancing both pointers and leaving count unchanged, including at full and at count=1.
REQ-021 SHALL pulse credit_out high for exactly one cycle, registered, in the cycle after each valid pop.
REQ-022 SHALL make credit_out pulses total exactly BUF_DEPTH per BUF_DEPTH flits drained; upstream starts with BUF_DEPTH credits.
REQ-023 SHALL, when valid_in=1 and a write is not accepted, drop the flit, leave pointers unchanged and set ovf_err the next cycle.
REQ-024 SHALL, when CHK_PROTO=1, run a write-side framing FSM with states IDLE and IN_PKT, using the package flit-type functions on accepted flits:
  - IDLE: head -> IN_PKT; single -> IDLE; body or tail -> set proto_err, stay IDLE.
  - IN_PKT: body -> IN_PKT; tail -> IDLE; head or single -> set proto_err, move to IN_PKT (head) or IDLE (single).
REQ-025 SHALL, when CHK_PROTO=0, tie proto_err to 0 and synthesize no FSM.
REQ-026 SHALL clear ovf_err and proto_err only by rst.
REQ-027 SHALL provide assertions, translated off for synthesis:
  - no X on data_in[1:0] when valid_in=1;
  - count never exceeds BUF_DEPTH;
  - valid_out == (count!=0).

Reset
REQ-028 SHALL, on rst, asynchronously clear wr_ptr, rd_ptr, count, credit_out, ovf_err and proto_err, and set the FSM to IDLE.
REQ-029 SHALL not reset storage contents; valid_out=0 SHALL mask them.
REQ-030 SHALL, on rst asserted mid-packet, discard all buffered flits and emit no credits for them; upstream credit state is reset by the same rst.

Structure
REQ-031 SHALL use the flit-type helpers (flit_is_head, flit_is_body, flit_is_tail, flit_is_single) and a new typedef inp_buf_state_t {IDLE, IN_PKT} from axi4_duth_noc_pkg.
REQ-032 SHALL be a single module with no sub-module; storage is an inferred register array.

Verification
REQ-033 Fill/drain: write 4 flits (BUF_DEPTH=4) back-to-back, no pop -> count=4, valid_out from cycle 1 onward; then pop 4 cycles -> data in order, 4 credit_out pulses each one cycle after its pop, count=0.
REQ-034 Full simultaneity: at count=4, valid_in=1 and pop=1 -> write accepted, count stays 4, one credit; then valid_in=1, pop=0 -> flit dropped, ovf_err=1 next cycle and stays set.
REQ-035 Wrap-around: stream 11 flits with pop every cycle after the first -> the pointers wrap twice, output order is exact and count never exceeds 1.
REQ-036 Framing: send head, body, head, tail -> proto_err rises the cycle after the second head; send single, tail -> proto_err is already sticky, and the FSM ends in IDLE.
REQ-037 Empty pop and reset: pop=1 with count=0 -> no credit and no change; assert rst with 3 flits buffered -> count=0, valid_out=0 and no credit pulses afterwards.
